lgn_image_loader: RTL and testbench

Front-end feeder for the `lgn` classifier. It accepts one 8-bit grayscale pixel per valid/ready transfer, thresholds each pixel to one bit, and packs the bits into bytes. It drives the classifier's `write_enable`/`ui_in` byte-shift port with exactly 98 bytes per 28×28 frame. After a programmable settle time it samples the classifier's 16-bit output, decodes the seven-segment digit back to a binary index, and presents the result.

---
 rtl/lgn_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 32 +++
 rtl/lgn_image_loader.sv | 160 ++++++++++++++++
 tb/tb_lgn_image_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lgn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lgn_pkg
//  Description : Shared frame geometry, loader FSM encoding and seven-segment
//                patterns for the lgn classifier and its front-end loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package lgn_pkg;

  localparam int LGN_PIXELS = 784;
  localparam int LGN_BYTES  = LGN_PIXELS / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_SETTLE = 2'd3
  } loader_state_t;

  // Segment patterns, bit 6 down to bit 0; identical to the classifier encoder.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111100;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Seven-segment pattern to binary digit, 4'hF when unmatched.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import lgn_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit
);

  always_comb begin
    digit = 4'hF;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: digit = 4'hF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lgn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lgn_image_loader
//  Description : Thresholds a pixel stream, packs it into 98 classifier bytes
//                per frame, then captures and decodes the classifier result.
//  Revision    : 1.0 - initial release
// ============================================================================
module lgn_image_loader
  import lgn_pkg::*;
#(
  parameter int PIXELS        = LGN_PIXELS,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  threshold,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_pixel,
  input  logic        s_last,
  output logic        lgn_we,
  output logic [7:0]  lgn_data,
  input  logic [15:0] lgn_result,
  output logic        result_valid,
  output logic [3:0]  result_digit,
  output logic [7:0]  result_score,
  output logic        frame_error
);

  localparam int         SC_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [9:0] LAST_PIX  = 10'(PIXELS - 1);
  localparam logic [6:0] LAST_BYTE = 7'(PIXELS / 8 - 1);
  localparam logic [SC_W-1:0] LAST_SETTLE = SC_W'(SETTLE_CYCLES - 1);

  loader_state_t   r_state;
  logic [9:0]      r_pix_cnt;
  logic [6:0]      r_byte_cnt;
  logic [SC_W-1:0] r_settle_cnt;
  logic [7:0]      r_pack;

  logic       w_accept;
  logic       w_bit;
  logic [7:0] w_pack_next;
  logic [7:0] w_fill;
  logic       w_byte_end;
  logic       w_last_pix;
  logic [3:0] w_digit;

  assign w_accept    = s_valid & s_ready;
  assign w_bit       = (s_pixel >= threshold);
  assign w_pack_next = {r_pack[6:0], w_bit};
  // Left-justify a partial byte so the missing trailing pixels read as zero.
  assign w_fill      = w_pack_next << (3'd7 - r_pix_cnt[2:0]);
  assign w_byte_end  = (r_pix_cnt[2:0] == 3'd7);
  assign w_last_pix  = (r_pix_cnt == LAST_PIX);

  seg7_decode u_decode (
    .seg   (lgn_result[6:0]),
    .digit (w_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_settle_cnt <= '0;
      r_pack       <= '0;
      s_ready      <= 1'b0;
      lgn_we       <= 1'b0;
      lgn_data     <= '0;
      result_valid <= 1'b0;
      result_digit <= '0;
      result_score <= '0;
      frame_error  <= 1'b0;
    end else begin
      lgn_we      <= 1'b0;
      frame_error <= 1'b0;

      case (r_state)
        ST_IDLE, ST_LOAD: begin
          s_ready <= 1'b1;
          if (w_accept) begin
            if (r_state == ST_IDLE) begin
              result_valid <= 1'b0;
            end
            r_state   <= ST_LOAD;
            r_pack    <= w_pack_next;
            r_pix_cnt <= r_pix_cnt + 10'd1;

            if (w_last_pix) begin
              // Full frame: the final pixel always completes byte 97.
              lgn_data     <= w_pack_next;
              lgn_we       <= 1'b1;
              frame_error  <= ~s_last;
              s_ready      <= 1'b0;
              r_state      <= ST_SETTLE;
              r_pix_cnt    <= '0;
              r_byte_cnt   <= '0;
              r_settle_cnt <= '0;
            end else if (s_last) begin
              lgn_data     <= w_fill;
              lgn_we       <= 1'b1;
              frame_error  <= 1'b1;
              s_ready      <= 1'b0;
              r_pix_cnt    <= '0;
              r_settle_cnt <= '0;
              if (r_byte_cnt == LAST_BYTE) begin
                r_state    <= ST_SETTLE;
                r_byte_cnt <= '0;
              end else begin
                r_state    <= ST_FLUSH;
                r_byte_cnt <= r_byte_cnt + 7'd1;
              end
            end else if (w_byte_end) begin
              lgn_data   <= w_pack_next;
              lgn_we     <= 1'b1;
              r_byte_cnt <= r_byte_cnt + 7'd1;
            end
          end
        end

        ST_FLUSH: begin
          s_ready  <= 1'b0;
          lgn_data <= 8'h00;
          lgn_we   <= 1'b1;
          if (r_byte_cnt == LAST_BYTE) begin
            r_state    <= ST_SETTLE;
            r_byte_cnt <= '0;
          end else begin
            r_byte_cnt <= r_byte_cnt + 7'd1;
          end
        end

        ST_SETTLE: begin
          s_ready <= 1'b0;
          if (r_settle_cnt == LAST_SETTLE) begin
            // Bit 7 low means the classifier still sees write_enable.
            result_valid <= 1'b1;
            result_score <= lgn_result[15:8];
            result_digit <= lgn_result[7] ? w_digit : 4'hF;
            frame_error  <= ~lgn_result[7];
            s_ready      <= 1'b1;
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + SC_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lgn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lgn_image_loader
//  Description : Directed frame vectors plus early-last and mid-frame reset
//                sequences, with a behavioural classifier shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lgn_image_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  threshold;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_pixel;
  logic        s_last;
  logic        lgn_we;
  logic [7:0]  lgn_data;
  logic [15:0] lgn_result;
  logic        result_valid;
  logic [3:0]  result_digit;
  logic [7:0]  result_score;
  logic        frame_error;

  always #5 clk = ~clk;

  lgn_image_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .threshold    (threshold),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_pixel      (s_pixel),
    .s_last       (s_last),
    .lgn_we       (lgn_we),
    .lgn_data     (lgn_data),
    .lgn_result   (lgn_result),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .result_score (result_score),
    .frame_error  (frame_error)
  );

  // Classifier stand-in: byte shift register, bit 7 of the result is ~write_enable.
  logic [783:0] cls = '0;
  logic [6:0]   m_seg;
  logic [7:0]   m_score;
  logic         m_bad;
  assign lgn_result = {m_score, m_bad ? 1'b0 : ~lgn_we, m_seg};
  always @(posedge clk) if (lgn_we) cls <= {cls[775:0], lgn_data};

  logic [7:0] bytes_q[$];
  int         err_cnt = 0;
  int         rdy_in_flush = 0;
  bit         flush_watch;
  always @(negedge clk) begin
    if (lgn_we) bytes_q.push_back(lgn_data);
    if (frame_error) err_cnt++;
    if (flush_watch && lgn_we && s_ready) rdy_in_flush++;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit abort    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [783:0] act, input logic [783:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [7:0] pix, input logic [7:0] thr, input bit last);
    int guard = 0;
    if (abort) return;
    s_valid = 1'b1; s_pixel = pix; threshold = thr; s_last = last;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      n_checks++; n_fail++; abort = 1;
      $display("FAIL push_timeout: s_ready got 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] thr,
                            input bit last_ok, input bit gaps);
    for (int i = 0; i < 784; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push((i % 2 == 1) ? b : a, thr, last_ok && (i == 783));
    end
  endtask

  // Latency in cycles from the negedge after the final write (counted as 1).
  task automatic wait_result(input string name, output int lat);
    lat = 1;
    while (!result_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_result_valid"}, result_valid, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] pix_a, pix_b, thr;
    bit         send_last, gaps, bad;
    logic [6:0] seg;
    logic [7:0] score;
    logic [7:0] exp_byte;
    logic [3:0] exp_digit;
    int         exp_errs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, base_b, base_e, nbad;
    logic [783:0] exp_cls;
    string nm;

    s_valid = 0; s_pixel = 0; s_last = 0; threshold = 0;
    m_seg = 0; m_score = 0; m_bad = 0; flush_watch = 0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {s_ready, lgn_we, lgn_data, result_valid, result_digit,
                            result_score, frame_error}, 24'h0);
    rst_n = 1'b1;
    check("ready_at_release", s_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", s_ready, 1'b1);

    //          a      b      thr    last gaps bad seg     score  byte   digit errs
    vecs[0] = '{8'd255, 8'd255, 8'd128, 1, 0, 0, 7'h7C, 8'h5A, 8'hFF, 4'd6, 0};
    vecs[1] = '{8'd10,  8'd200, 8'd128, 1, 0, 0, 7'h3F, 8'h11, 8'h55, 4'd0, 0};
    vecs[2] = '{8'd128, 8'd127, 8'd128, 1, 1, 0, 7'h67, 8'hC3, 8'hAA, 4'd9, 0};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   1, 1, 0, 7'h00, 8'h00, 8'hFF, 4'hF, 0};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 1, 0, 1, 7'h06, 8'h7E, 8'hFF, 4'hF, 1};
    vecs[5] = '{8'd0,   8'd0,   8'd1,   0, 0, 0, 7'h5B, 8'h21, 8'h00, 4'd2, 1};
    vecs[6] = '{8'd200, 8'd10,  8'd200, 1, 1, 0, 7'h7F, 8'h88, 8'hAA, 4'd8, 0};
    vecs[7] = '{8'd199, 8'd200, 8'd200, 1, 0, 0, 7'h6D, 8'h01, 8'h55, 4'd5, 0};

    for (int r = 0; r < 8; r++) begin
      nm = $sformatf("row%0d", r);
      m_seg = vecs[r].seg; m_score = vecs[r].score; m_bad = vecs[r].bad;
      base_b = bytes_q.size(); base_e = err_cnt;
      send_frame(vecs[r].pix_a, vecs[r].pix_b, vecs[r].thr, vecs[r].send_last, vecs[r].gaps);
      wait_result(nm, lat);
      check({nm, "_latency"}, lat, 5);
      check({nm, "_byte_count"}, bytes_q.size() - base_b, 98);
      nbad = 0;
      for (int i = base_b; i < bytes_q.size(); i++) if (bytes_q[i] !== vecs[r].exp_byte) nbad++;
      check({nm, "_byte_values_bad"}, nbad, 0);
      exp_cls = {98{vecs[r].exp_byte}};
      check_wide({nm, "_classifier"}, cls, exp_cls);
      check({nm, "_digit"}, result_digit, vecs[r].exp_digit);
      check({nm, "_score"}, result_score, vecs[r].score);
      check({nm, "_frame_errors"}, err_cnt - base_e, vecs[r].exp_errs);
      m_bad = 0;
    end

    // Early s_last on pixel 9: FF, C0, then 96 zero bytes from FLUSH.
    m_seg = 7'h4F; m_score = 8'h33;
    base_b = bytes_q.size(); base_e = err_cnt;
    for (int i = 0; i < 8; i++) push(8'd255, 8'd128, 1'b0);
    check("byte_latency_we", lgn_we, 1'b1);
    check("byte_latency_data", lgn_data, 8'hFF);
    push(8'd255, 8'd128, 1'b0);
    push(8'd255, 8'd128, 1'b1);
    check("early_err_pulse", frame_error, 1'b1);
    check("early_ready_low", s_ready, 1'b0);
    check("early_partial_byte", lgn_data, 8'hC0);
    flush_watch = 1;
    wait_result("early", lat);
    flush_watch = 0;
    check("early_latency", lat, 101);
    check("early_byte_count", bytes_q.size() - base_b, 98);
    nbad = 0;
    for (int i = base_b; i < bytes_q.size(); i++) begin
      if (i == base_b) begin
        if (bytes_q[i] !== 8'hFF) nbad++;
      end else if (i == base_b + 1) begin
        if (bytes_q[i] !== 8'hC0) nbad++;
      end else if (bytes_q[i] !== 8'h00) nbad++;
    end
    check("early_byte_values_bad", nbad, 0);
    check_wide("early_classifier", cls, {8'hFF, 8'hC0, 768'h0});
    check("early_frame_errors", err_cnt - base_e, 1);
    check("early_ready_in_flush", rdy_in_flush, 0);
    check("early_digit", result_digit, 4'd3);
    check("early_score", result_score, 8'h33);

    // Reset after 300 pixels, then a complete frame.
    m_seg = 7'h66; m_score = 8'h44;
    for (int i = 0; i < 300; i++) push((i % 2 == 1) ? 8'd200 : 8'd10, 8'd128, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {s_ready, lgn_we, lgn_data, result_valid, result_digit,
                               result_score, frame_error}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base_b = bytes_q.size(); base_e = err_cnt;
    send_frame(8'd10, 8'd200, 8'd128, 1'b1, 1'b0);
    wait_result("after_reset", lat);
    check("after_reset_byte_count", bytes_q.size() - base_b, 98);
    nbad = 0;
    for (int i = base_b; i < bytes_q.size(); i++) if (bytes_q[i] !== 8'h55) nbad++;
    check("after_reset_byte_values_bad", nbad, 0);
    check_wide("after_reset_classifier", cls, {98{8'h55}});
    check("after_reset_digit", result_digit, 4'd4);
    check("after_reset_score", result_score, 8'h44);
    check("after_reset_frame_errors", err_cnt - base_e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
